// File: rtl/uart_rx.sv
// 8-N-1 UART receiver with start-glitch rejection, mid-bit sampling and framing-error detection.
// Define UART_RX_PARITY_EN to receive 8-E-1 frames and report parity mismatches on perr.
module uart_rx #(
  parameter int CLK_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rxd,
  output logic [7:0] r_data,
  output logic       rx_ready,
  output logic       ferr,
  output logic       perr
);

  localparam int H  = CLK_PER_BIT / 2;
  localparam int CW = $clog2(CLK_PER_BIT);
  localparam logic [CW-1:0] CNT_HALF = CW'(H - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(CLK_PER_BIT - 1);

  generate
    if (CLK_PER_BIT < 4) begin : g_bad_clk_per_bit
      $error("uart_rx: CLK_PER_BIT must be at least 4");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP, WAIT_HIGH
  } state_t;

  state_t          state, next_state;
  logic            rxd_meta, rxd_s;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shift_reg;
  logic            bit_tick;
  logic            load_byte, frame_err;

  assign bit_tick = (cnt == CNT_FULL);

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rxd_meta <= 1'b1;
      rxd_s    <= 1'b1;
    end else begin
      rxd_meta <= rxd;
      rxd_s    <= rxd_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (!rxd_s) next_state = START;
      START:     if (cnt == CNT_HALF) next_state = rxd_s ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
      DATA:      if (bit_tick && bit_idx == 3'd7) next_state = PARITY;
      PARITY:    if (bit_tick) next_state = STOP;
`else
      DATA:      if (bit_tick && bit_idx == 3'd7) next_state = STOP;
`endif
      STOP:      if (bit_tick) next_state = rxd_s ? IDLE : WAIT_HIGH;
      WAIT_HIGH: if (rxd_s) next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  always_comb begin
    load_byte = 1'b0;
    frame_err = 1'b0;
    if (state == STOP && bit_tick) begin
      load_byte = rxd_s;
      frame_err = !rxd_s;
    end
  end

  // Counter restarts on every state change and at each data-bit sample.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt       <= '0;
      bit_idx   <= 3'd0;
      shift_reg <= 8'd0;
    end else begin
      if (state != next_state || (state == DATA && bit_tick)) cnt <= '0;
      else                                                      cnt <= cnt + 1'b1;
      if (state == START) bit_idx <= 3'd0;
      if (state == DATA && bit_tick) begin
        shift_reg <= {rxd_s, shift_reg[7:1]};
        bit_idx   <= bit_idx + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_data   <= 8'd0;
      rx_ready <= 1'b0;
      ferr     <= 1'b0;
    end else begin
      rx_ready <= load_byte;
      ferr     <= frame_err;
      if (load_byte) r_data <= shift_reg;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_err;

  // Even parity: the received parity bit must equal the XOR of the data bits.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      par_err <= 1'b0;
      perr    <= 1'b0;
    end else begin
      if (state == START) par_err <= 1'b0;
      if (state == PARITY && bit_tick) par_err <= rxd_s ^ (^shift_reg);
      perr <= load_byte & par_err;
    end
  end
`else
  assign perr = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 16 clocks per bit; frame timing is modelled from the line protocol.
// Honours UART_RX_PARITY_EN the same way as the design.
module tb_uart_rx;

  localparam int N = 16;
  localparam int H = N / 2;
`ifdef UART_RX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  // Line edge to strobe: 3 cycles of synchroniser lag, then the stop-bit sample point.
  localparam int LAT = 3 + H + (FB - 1) * N;

  typedef struct {
    logic [7:0] data;
    logic       par;
    int         cyc;
  } ev_t;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       rxd = 1'b1;
  logic [7:0] r_data;
  logic       rx_ready, ferr, perr;

  int         cyc = 0;
  int         checks = 0;
  int         fails = 0;
  int         stray_perr = 0;
  int         both_strobes = 0;
  logic [7:0] last_good = 8'd0;

  ev_t        rdy_q[$];
  int         ferr_cyc_q[$];
  logic [7:0] ferr_data_q[$];

  uart_rx #(.CLK_PER_BIT(N)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .rxd      (rxd),
    .r_data   (r_data),
    .rx_ready (rx_ready),
    .ferr     (ferr),
    .perr     (perr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rstn) begin
      if (rx_ready) rdy_q.push_back('{data: r_data, par: perr, cyc: cyc});
      if (ferr) begin
        ferr_cyc_q.push_back(cyc);
        ferr_data_q.push_back(r_data);
      end
      if (perr && !rx_ready) stray_perr++;
      if (rx_ready && ferr) both_strobes++;
    end
  end

  task automatic clear_events();
    rdy_q.delete();
    ferr_cyc_q.delete();
    ferr_data_q.delete();
  endtask

  // Called at a negedge; drives one full frame and returns at the negedge after the stop bit.
  task automatic send_frame(input logic [7:0] d, input logic par_bad, input logic stop_bit,
                            output int t_start);
    rxd = 1'b0;
    t_start = cyc;
    repeat (N) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      rxd = d[k];
      repeat (N) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    rxd = (^d) ^ par_bad;
    repeat (N) @(negedge clk);
`endif
    rxd = stop_bit;
    repeat (N) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (r_data !== 8'd0) begin fails++; $display("[TB] FAIL reset_r_data: got %h want 00", r_data); end
    checks++; if (rx_ready !== 1'b0) begin fails++; $display("[TB] FAIL reset_rx_ready: got %b want 0", rx_ready); end
    checks++; if (ferr !== 1'b0) begin fails++; $display("[TB] FAIL reset_ferr: got %b want 0", ferr); end
    checks++; if (perr !== 1'b0) begin fails++; $display("[TB] FAIL reset_perr: got %b want 0", perr); end
    rstn = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if (rx_ready !== 1'b0 || ferr !== 1'b0) begin
      fails++; $display("[TB] FAIL idle_strobes: got rx_ready=%b ferr=%b want 0/0", rx_ready, ferr);
    end
  endtask

  task automatic test_single_byte();
    int t;
    clear_events();
    send_frame(8'h55, 1'b0, 1'b1, t);
    last_good = 8'h55;
    checks++; if (rdy_q.size() !== 1) begin fails++; $display("[TB] FAIL single_count: got %0d want 1", rdy_q.size()); end
    if (rdy_q.size() > 0) begin
      checks++; if (rdy_q[0].data !== 8'h55) begin fails++; $display("[TB] FAIL single_data: got %h want 55", rdy_q[0].data); end
      checks++; if (rdy_q[0].cyc !== t + LAT) begin fails++; $display("[TB] FAIL single_latency: got %0d want %0d", rdy_q[0].cyc - t, LAT); end
      checks++; if (rdy_q[0].par !== 1'b0) begin fails++; $display("[TB] FAIL single_perr: got %b want 0", rdy_q[0].par); end
    end
    checks++; if (ferr_cyc_q.size() !== 0) begin fails++; $display("[TB] FAIL single_ferr: got %0d pulses want 0", ferr_cyc_q.size()); end
    checks++; if (r_data !== 8'h55 || rx_ready !== 1'b0) begin
      fails++; $display("[TB] FAIL single_hold: got r_data=%h rx_ready=%b want 55/0", r_data, rx_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [3];
    int t [3];
    bytes[0] = 8'hA3; bytes[1] = 8'h00; bytes[2] = 8'hFF;
    clear_events();
    for (int i = 0; i < 3; i++) send_frame(bytes[i], 1'b0, 1'b1, t[i]);
    last_good = 8'hFF;
    checks++; if (rdy_q.size() !== 3) begin fails++; $display("[TB] FAIL b2b_count: got %0d want 3", rdy_q.size()); end
    for (int i = 0; i < 3 && i < rdy_q.size(); i++) begin
      checks++; if (rdy_q[i].data !== bytes[i]) begin fails++; $display("[TB] FAIL b2b_data%0d: got %h want %h", i, rdy_q[i].data, bytes[i]); end
      checks++; if (rdy_q[i].cyc !== t[0] + LAT + i * FB * N) begin
        fails++; $display("[TB] FAIL b2b_time%0d: got %0d want %0d", i, rdy_q[i].cyc - t[0], LAT + i * FB * N);
      end
    end
  endtask

  task automatic test_glitch();
    int t;
    clear_events();
    rxd = 1'b0;
    repeat (4) @(negedge clk);
    rxd = 1'b1;
    repeat (2 * N) @(negedge clk);
    checks++; if (rdy_q.size() !== 0 || ferr_cyc_q.size() !== 0) begin
      fails++; $display("[TB] FAIL glitch_strobe: got rdy=%0d ferr=%0d want 0/0", rdy_q.size(), ferr_cyc_q.size());
    end
    send_frame(8'h3C, 1'b0, 1'b1, t);
    last_good = 8'h3C;
    checks++; if (rdy_q.size() !== 1) begin fails++; $display("[TB] FAIL glitch_follow_count: got %0d want 1", rdy_q.size()); end
    if (rdy_q.size() > 0) begin
      checks++; if (rdy_q[0].data !== 8'h3C) begin fails++; $display("[TB] FAIL glitch_follow_data: got %h want 3c", rdy_q[0].data); end
    end
  endtask

  task automatic test_framing_error();
    int t;
    logic [7:0] prev;
    prev = last_good;
    clear_events();
    send_frame(8'h81, 1'b0, 1'b0, t);
    repeat (50) @(negedge clk);
    checks++; if (ferr_cyc_q.size() !== 1) begin fails++; $display("[TB] FAIL ferr_count: got %0d want 1", ferr_cyc_q.size()); end
    if (ferr_cyc_q.size() > 0) begin
      checks++; if (ferr_cyc_q[0] !== t + LAT) begin fails++; $display("[TB] FAIL ferr_time: got %0d want %0d", ferr_cyc_q[0] - t, LAT); end
      checks++; if (ferr_data_q[0] !== prev) begin fails++; $display("[TB] FAIL ferr_r_data: got %h want %h", ferr_data_q[0], prev); end
    end
    checks++; if (rdy_q.size() !== 0) begin fails++; $display("[TB] FAIL ferr_no_ready: got %0d pulses want 0", rdy_q.size()); end
    rxd = 1'b1;
    repeat (N) @(negedge clk);
    send_frame(8'h42, 1'b0, 1'b1, t);
    last_good = 8'h42;
    checks++; if (rdy_q.size() !== 1 || ferr_cyc_q.size() !== 1) begin
      fails++; $display("[TB] FAIL ferr_recover_count: got rdy=%0d ferr=%0d want 1/1", rdy_q.size(), ferr_cyc_q.size());
    end
    if (rdy_q.size() > 0) begin
      checks++; if (rdy_q[0].data !== 8'h42) begin fails++; $display("[TB] FAIL ferr_recover_data: got %h want 42", rdy_q[0].data); end
    end
  endtask

  task automatic test_mid_frame_reset();
    int t;
    logic [7:0] d;
    d = 8'hA5;
    clear_events();
    rxd = 1'b0;
    repeat (N) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      rxd = d[k];
      repeat (N) @(negedge clk);
    end
    rxd = d[4];
    repeat (H) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    checks++; if (r_data !== 8'd0 || rx_ready !== 1'b0 || ferr !== 1'b0 || perr !== 1'b0) begin
      fails++; $display("[TB] FAIL midreset_outputs: got r_data=%h rx_ready=%b ferr=%b perr=%b want 00/0/0/0", r_data, rx_ready, ferr, perr);
    end
    rxd = 1'b1;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    last_good = 8'd0;
    repeat (2 * N) @(negedge clk);
    checks++; if (rdy_q.size() !== 0 || ferr_cyc_q.size() !== 0) begin
      fails++; $display("[TB] FAIL midreset_aborted: got rdy=%0d ferr=%0d want 0/0", rdy_q.size(), ferr_cyc_q.size());
    end
    send_frame(8'h7E, 1'b0, 1'b1, t);
    last_good = 8'h7E;
    checks++; if (rdy_q.size() !== 1) begin fails++; $display("[TB] FAIL midreset_count: got %0d want 1", rdy_q.size()); end
    if (rdy_q.size() > 0) begin
      checks++; if (rdy_q[0].data !== 8'h7E) begin fails++; $display("[TB] FAIL midreset_data: got %h want 7e", rdy_q[0].data); end
    end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    int t;
    clear_events();
    send_frame(8'h07, 1'b1, 1'b1, t);
    send_frame(8'h07, 1'b0, 1'b1, t);
    last_good = 8'h07;
    checks++; if (rdy_q.size() !== 2) begin fails++; $display("[TB] FAIL parity_count: got %0d want 2", rdy_q.size()); end
    if (rdy_q.size() > 1) begin
      checks++; if (rdy_q[0].data !== 8'h07 || rdy_q[0].par !== 1'b1) begin
        fails++; $display("[TB] FAIL parity_bad: got data=%h perr=%b want 07/1", rdy_q[0].data, rdy_q[0].par);
      end
      checks++; if (rdy_q[1].data !== 8'h07 || rdy_q[1].par !== 1'b0) begin
        fails++; $display("[TB] FAIL parity_good: got data=%h perr=%b want 07/0", rdy_q[1].data, rdy_q[1].par);
      end
    end
  endtask
`endif

  task automatic test_random();
    ev_t exp_q[$];
    logic [7:0] b;
    logic pb;
    int t, gap;
    clear_events();
    for (int i = 0; i < 10; i++) begin
      b = 8'($urandom);
`ifdef UART_RX_PARITY_EN
      pb = 1'($urandom_range(0, 1));
`else
      pb = 1'b0;
`endif
      gap = $urandom_range(0, 20);
      repeat (gap) @(negedge clk);
      send_frame(b, pb, 1'b1, t);
      exp_q.push_back('{data: b, par: pb, cyc: t + LAT});
      last_good = b;
    end
    checks++; if (rdy_q.size() !== exp_q.size()) begin
      fails++; $display("[TB] FAIL random_count: got %0d want %0d", rdy_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < rdy_q.size(); i++) begin
      checks++; if (rdy_q[i].data !== exp_q[i].data || rdy_q[i].par !== exp_q[i].par || rdy_q[i].cyc !== exp_q[i].cyc) begin
        fails++; $display("[TB] FAIL random_frame%0d: got data=%h perr=%b cyc=%0d want %h/%b/%0d",
                          i, rdy_q[i].data, rdy_q[i].par, rdy_q[i].cyc, exp_q[i].data, exp_q[i].par, exp_q[i].cyc);
      end
    end
    checks++; if (r_data !== last_good) begin fails++; $display("[TB] FAIL random_hold: got %h want %h", r_data, last_good); end
  endtask

  initial begin
    $display("[TB] uart_rx bench, CLK_PER_BIT=%0d, frame bits=%0d", N, FB);
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_glitch();
    test_framing_error();
    test_mid_frame_reset();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_random();
    checks++; if (stray_perr !== 0) begin fails++; $display("[TB] FAIL stray_perr: got %0d want 0", stray_perr); end
    checks++; if (both_strobes !== 0) begin fails++; $display("[TB] FAIL ready_and_ferr: got %0d want 0", both_strobes); end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver for the serial console path: recovers 8-N-1 frames from the asynchronous `rxd` pin and hands each byte to the loopback/command core as `r_data` with a one-cycle `rx_ready` strobe. It sits directly upstream of the loopback core and has no back-pressure. The consumer must take each byte in the cycle `rx_ready` is high. The block provides input synchronisation, start-bit glitch rejection, mid-bit sampling and framing-error detection.

## Interface
- `CLK_PER_BIT`, default 868: clk cycles per bit (100 MHz / 115200). Legal range ≥ 4; this is checked at elaboration. Let N = `CLK_PER_BIT` and H = N/2 (integer division).
- `clk`  in  1  system clock, rising-edge.
- `rstn`  in  1  synchronous, active-low reset.
- `rxd`  in  1  asynchronous serial input, idle high.
- `r_data`  out  8  last good byte, LSB = first data bit received. It holds its value until the next good frame.
- `rx_ready`  out  1  one-cycle pulse when `r_data` is updated.
- `ferr`  out  1  one-cycle pulse when the stop bit is sampled low.
- `perr`  out  1  one-cycle pulse on parity mismatch. It is constant 0 when parity is compiled out.

## Operation
- Synchroniser: two flops on `rxd`, both reset to 1. The FSM only sees the second flop's output, `rxd_s`.
- Counter: `$clog2(N)` bits, cleared on every state change. Bit index: 3 bits. Shift register: 8 bits, LSB-first, shifting in from the MSB end.
- States:
  - IDLE: if `rxd_s`=0, go to START and mark this edge as t0.
  - START: at count H-1 (edge t0+H), sample `rxd_s`. If it is 0, go to DATA; if it is 1, treat it as a glitch and go to IDLE with no output.
  - DATA: every N cycles, sample `rxd_s` into the shift register. After bit 7, go to PARITY (macro on) or STOP (macro off).
  - PARITY: after N cycles, sample and compare against even parity of the data.
  - STOP: after N cycles, sample. If 1: load `r_data` from the shift register, pulse `rx_ready` (plus `perr` if a mismatch was recorded), go to IDLE. If 0: pulse `ferr`, leave `r_data` unchanged, suppress `rx_ready`, go to WAIT_HIGH.
  - WAIT_HIGH: stay until `rxd_s`=1, then go to IDLE. This prevents a break condition from being re-read as a start bit.
- A return to IDLE at mid-stop-bit is intentional. It allows a back-to-back next start bit to be detected on time.
- Reset, including mid-frame, forces:
  - FSM to IDLE;
  - `r_data`=0, `rx_ready`=0, `ferr`=0, `perr`=0;
  - counter and shift register to 0.

## Timing
- Sample edges, relative to t0:
  - start bit at t0+H;
  - data bit k (0..7) at t0+H+(k+1)·N;
  - parity bit at t0+H+9N;
  - stop bit at t0+H+9N (macro off) or t0+H+10N (macro on).
- `rx_ready`, `ferr` and `perr` are registered at the stop-sample edge and are high for exactly the following cycle.
- `r_data` is valid in the same cycle that `rx_ready` is high.
- t0 lags the physical falling edge on `rxd` by 2–3 clk cycles because of synchroniser latency.
- `rx_ready` and `ferr` are mutually exclusive. `perr` may coincide with `rx_ready`; the byte is still delivered.
- Minimum gap between strobes is one frame (10N or 11N cycles). The block has no buffering.

## Configuration
- Macro `UART_RX_PARITY_EN`.
- Defined: frame is 8-E-1. The PARITY state exists, a mismatch pulses `perr` together with `rx_ready`, and the frame is 11 bits.
- Undefined: frame is 8-N-1. There is no PARITY state, `perr` is tied to 0, and the frame is 10 bits.

## Test plan
- Run all cases with N=16. `rx_ready` must pulse exactly once per frame.
- Byte 0x55 at 16 cycles/bit, macro off: `rx_ready` pulse with `r_data`=0x55, occurring at t0+8+144; `ferr`=0.
- Back-to-back frames 0xA3, 0x00, 0xFF with no idle gap: three `rx_ready` pulses 160 cycles apart with `r_data` 0xA3, 0x00, 0xFF.
- Start-bit glitch: `rxd` low for 4 cycles, then high: no strobe. A following valid 0x3C is received correctly.
- Frame 0x81 with stop bit driven 0 and the line held low for 50 cycles: `ferr` pulses once, `r_data` keeps its previous value, no `rx_ready`. The FSM waits for `rxd` high, then a subsequent 0x42 is received.
- `rstn` asserted at data bit 4 of a frame: all outputs 0 the next cycle. After release, a fresh frame 0x7E is received with `r_data`=0x7E.
- Macro on, frame 0x07 with parity bit 0 (wrong; even parity is 1): `rx_ready`, `perr` and `r_data`=0x07 all in the same cycle.
